// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among N_REQ byte producers. A winner's byte is
// registered onto uart_tx_data, uart_tx_ready is raised to launch the frame,
// and the requester is acknowledged once the transmitter reports busy.
//
// Build option: define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest
// asserted index wins). Without it, the arbiter is round-robin. Timing is
// identical in both builds.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,   // 2..8
  parameter int GAP_CYCLES   = 2,   // 1..15
  parameter int BUSY_TIMEOUT = 15   // 4..255
) (
  input  logic                 sys_clk_100M,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  output logic [2:0]           grant_id,
  output logic                 arb_busy,
  output logic                 timeout_err,
  output logic                 uart_tx_ready,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } state_t;

  localparam logic [N_REQ-1:0] ACK_ONE  = N_REQ'(1);
  localparam logic [7:0]       TMO_LAST = 8'(BUSY_TIMEOUT - 1);
  localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic [7:0] tmo_cnt;
  logic [3:0] gap_cnt;

  logic       win_vld;
  logic [2:0] win_id;
  logic [7:0] win_data;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
`else
  logic [2:0] ptr;
`endif

  // Pick the next requester to serve from the current request vector.
  always_comb begin : pick_winner
`ifdef UART_TX_ARB_FIXED_PRIO_EN
`else
    int idx;
    idx      = 0;
`endif
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    win_vld  = 1'b0;
    win_id   = '0;
    win_data = '0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    // Walk downward so the lowest asserted index is the last (winning) write.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld  = 1'b1;
        win_id   = 3'(i);
        win_data = req_data[8*i +: 8];
      end
    end
`else
    // Walk from the farthest slot back to pointer+1 so the first set bit
    // after the pointer (modulo N_REQ) is the last write and wins.
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        win_vld  = 1'b1;
        win_id   = 3'(idx);
        win_data = req_data[8*idx +: 8];
      end
    end
`endif
  end

  // Arbitration FSM with registered handshake outputs.
  always_ff @(posedge sys_clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      gap_cnt       <= '0;
      ack           <= '0;
      grant_id      <= '0;
      arb_busy      <= 1'b0;
      timeout_err   <= 1'b0;
      uart_tx_ready <= 1'b0;
      uart_tx_data  <= '0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
`else
      ptr           <= 3'(N_REQ - 1);
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // sees the pre-edge values of the others, matching real flip-flops.
      ack         <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            uart_tx_data  <= win_data;
            grant_id      <= win_id;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
`else
            ptr           <= win_id;
`endif
            uart_tx_ready <= 1'b1;
            arb_busy      <= 1'b1;
            tmo_cnt       <= '0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (uart_tx_busy) begin
            uart_tx_ready <= 1'b0;
            ack           <= ACK_ONE << grant_id;
            state         <= WAIT_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            // Abandon this byte; the pointer already moved past the requester.
            uart_tx_ready <= 1'b0;
            timeout_err   <= 1'b1;
            gap_cnt       <= '0;
            state         <= GAP;
          end else if (tmo_cnt != 8'hFF) begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!uart_tx_busy) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          // Hold tx_ready low long enough for the transmitter's synchronizer.
          if (gap_cnt == GAP_LAST) begin
            arb_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural transmitter
// (2-flop synchronizer + edge detect, 4 cycles per bit, 10-bit frame).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N_REQ        = 4;
  localparam int GAP_CYCLES   = 2;
  localparam int BUSY_TIMEOUT = 15;
  localparam int BIT_CYC      = 4;
  localparam int FRAME_CYC    = 10 * BIT_CYC;
  localparam int WAIT_LIMIT   = 300;

  logic                 sys_clk_100M = 1'b0;
  logic                 rst_n = 1'b1;
  logic [N_REQ-1:0]     req = '0;
  logic [8*N_REQ-1:0]   req_data = '0;
  logic [N_REQ-1:0]     ack;
  logic [2:0]           grant_id;
  logic                 arb_busy;
  logic                 timeout_err;
  logic                 uart_tx_ready;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_busy;

  always #5 sys_clk_100M = ~sys_clk_100M;

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .GAP_CYCLES   (GAP_CYCLES),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .sys_clk_100M  (sys_clk_100M),
    .rst_n         (rst_n),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .grant_id      (grant_id),
    .arb_busy      (arb_busy),
    .timeout_err   (timeout_err),
    .uart_tx_ready (uart_tx_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_busy  (uart_tx_busy)
  );

  // Transmitter model: busy rises 3 cycles after tx_ready rises.
  logic       tx_en = 1'b1;
  logic [2:0] tx_sync;
  logic [9:0] tx_shift;
  int         tx_cnt;
  logic       tx_line;
  logic [9:0] frame_cap = '0;

  always @(posedge sys_clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      tx_sync      <= '0;
      uart_tx_busy <= 1'b0;
      tx_shift     <= '1;
      tx_cnt       <= 0;
    end else begin
      tx_sync <= {tx_sync[1:0], uart_tx_ready};
      if (!uart_tx_busy) begin
        if (tx_en && tx_sync[1] && !tx_sync[2]) begin
          uart_tx_busy <= 1'b1;
          tx_shift     <= {1'b1, uart_tx_data, 1'b0};
          tx_cnt       <= 0;
        end
      end else begin
        tx_cnt <= tx_cnt + 1;
        if (tx_cnt % BIT_CYC == BIT_CYC - 1) tx_shift <= {1'b1, tx_shift[9:1]};
        if (tx_cnt == FRAME_CYC - 1) uart_tx_busy <= 1'b0;
      end
    end
  end

  assign tx_line = uart_tx_busy ? tx_shift[0] : 1'b1;

  // Protocol monitor: ack/timeout counts, pulse widths, data stability.
  int               ack_cnt [N_REQ];
  int               tmo_pulses = 0;
  int               proto_err = 0;
  logic [N_REQ-1:0] ack_q = '0;
  logic             tmo_q = 1'b0;
  logic             ready_q = 1'b0;
  logic [7:0]       data_q = '0;
  logic             rst_q = 1'b0;

  always @(negedge sys_clk_100M) begin
    if (uart_tx_busy && (tx_cnt % BIT_CYC == 1)) frame_cap[tx_cnt / BIT_CYC] = tx_line;
    for (int i = 0; i < N_REQ; i++) if (ack[i]) ack_cnt[i]++;
    if (timeout_err) tmo_pulses++;
    if (ack != '0 && ($countones(ack) != 1 || timeout_err)) proto_err++;
    if ((ack != '0 && ack_q != '0) || (timeout_err && tmo_q)) proto_err++;
    if (rst_n && rst_q && uart_tx_data != data_q && !(uart_tx_ready && !ready_q)) proto_err++;
    ack_q   = ack;
    tmo_q   = timeout_err;
    ready_q = uart_tx_ready;
    data_q  = uart_tx_data;
    rst_q   = rst_n;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_ack(output int cycles);
    cycles = 0;
    while (ack == '0 && cycles < WAIT_LIMIT) begin
      @(negedge sys_clk_100M);
      cycles++;
    end
  endtask

  task automatic wait_idle();
    int cycles;
    cycles = 0;
    while (arb_busy && cycles < WAIT_LIMIT) begin
      @(negedge sys_clk_100M);
      cycles++;
    end
    check("return to idle", {31'd0, arb_busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ack"},         {28'd0, ack},           32'd0);
    check({tag, " grant_id"},    {29'd0, grant_id},      32'd0);
    check({tag, " arb_busy"},    {31'd0, arb_busy},      32'd0);
    check({tag, " timeout_err"}, {31'd0, timeout_err},   32'd0);
    check({tag, " tx_ready"},    {31'd0, uart_tx_ready}, 32'd0);
    check({tag, " tx_data"},     {24'd0, uart_tx_data},  32'd0);
  endtask

  initial begin
    int               n;
    int               exp_order [5];
    logic [N_REQ-1:0] exp_ack;
    logic [2:0]       exp_id3;
    longint           t_prev;
    longint           t_now;
    int               ack1_before;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
    exp_id3   = 3'd1;
`else
    exp_order = '{0, 1, 2, 3, 0};
    exp_id3   = 3'd3;
`endif
    t_prev = 0;

    // Reset state.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge sys_clk_100M);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk_100M);

    // Single request, data 0xA5.
    req_data = 32'h0000_00A5;
    req      = 4'b0001;
    check("t1 ready low before edge", {31'd0, uart_tx_ready}, 32'd0);
    @(negedge sys_clk_100M);
    check("t1 ready after 1 cycle", {31'd0, uart_tx_ready}, 32'd1);
    check("t1 grant_id", {29'd0, grant_id}, 32'd0);
    check("t1 tx_data", {24'd0, uart_tx_data}, 32'h A5);
    check("t1 arb_busy", {31'd0, arb_busy}, 32'd1);
    wait_ack(n);
    check("t1 ack latency", n, 32'd4);
    check("t1 ack", {28'd0, ack}, 32'b0001);
    check("t1 ready falls with ack", {31'd0, uart_tx_ready}, 32'd0);
    req = '0;
    wait_idle();
    check("t1 tx frame", {22'd0, frame_cap}, 32'b11_0100_1010);
    check("t1 ack count", ack_cnt[0], 32'd1);

    // All requesters held; pointer restored by an idle reset pulse.
    rst_n = 1'b0;
    @(negedge sys_clk_100M);
    rst_n = 1'b1;
    @(negedge sys_clk_100M);
    req_data = 32'h4332_2110;
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(n);
      t_now   = $time;
      exp_ack = N_REQ'(1) << exp_order[k];
      check($sformatf("t2 ack %0d", k), {28'd0, ack}, {28'd0, exp_ack});
      check($sformatf("t2 grant %0d", k), {29'd0, grant_id}, exp_order[k]);
      check($sformatf("t2 data %0d", k), {24'd0, uart_tx_data}, 32'h10 + 32'h11 * exp_order[k]);
      if (k > 0)
        check($sformatf("t2 spacing ok %0d", k),
              {31'd0, ((t_now - t_prev) / 10) >= longint'(FRAME_CYC + GAP_CYCLES + 2)}, 32'd1);
      t_prev = t_now;
      @(negedge sys_clk_100M);
    end
    req = '0;
    wait_idle();

    // Transmitter never answers: timeout on requester 1.
    tx_en    = 1'b0;
    req_data = 32'h0000_5A00;
    req      = 4'b0010;
    @(negedge sys_clk_100M);
    check("t3 grant_id", {29'd0, grant_id}, 32'd1);
    n = 0;
    while (!timeout_err && n < WAIT_LIMIT) begin
      @(negedge sys_clk_100M);
      n++;
    end
    check("t3 timeout latency", n, BUSY_TIMEOUT);
    check("t3 no ack at timeout", {28'd0, ack}, 32'd0);
    check("t3 ready low", {31'd0, uart_tx_ready}, 32'd0);
    tx_en    = 1'b1;
    req_data = 32'hC300_5A00;
    req      = 4'b1010;
    wait_ack(n);
    check("t3 next grant", {29'd0, grant_id}, {29'd0, exp_id3});
    check("t3 next ack", {28'd0, ack}, 32'd1 << exp_id3);
    req = '0;
    wait_idle();
    check("t3 timeout pulses", tmo_pulses, 32'd1);

    // Reset mid-frame with requester 2 and 3 pending.
    req_data = 32'h0000_0077;
    req      = 4'b0001;
    wait_ack(n);
    check("t4 ack", {28'd0, ack}, 32'b0001);
    req      = 4'b1100;
    req_data = 32'hDDCC_0077;
    repeat (5) @(negedge sys_clk_100M);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("t4 in reset");
    repeat (2) @(negedge sys_clk_100M);
    rst_n = 1'b1;
    wait_ack(n);
    check("t4 first after reset", {29'd0, grant_id}, 32'd2);
    check("t4 data after reset", {24'd0, uart_tx_data}, 32'hCC);
    req = '0;
    wait_idle();

    // Requester 1 drops req during WAIT_DONE.
    ack1_before = ack_cnt[1];
    req_data    = 32'h0000_3C00;
    req         = 4'b0010;
    wait_ack(n);
    check("t5 ack", {28'd0, ack}, 32'b0010);
    repeat (5) @(negedge sys_clk_100M);
    check("t5 still busy", {31'd0, arb_busy}, 32'd1);
    req = '0;
    wait_idle();
    repeat (10) @(negedge sys_clk_100M);
    check("t5 single ack", ack_cnt[1] - ack1_before, 32'd1);
    check("t5 ready stays low", {31'd0, uart_tx_ready}, 32'd0);
    check("t5 stays idle", {31'd0, arb_busy}, 32'd0);

    check("protocol violations", proto_err, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
